// File: rtl/alu_pipe.sv
// Handshaked, registered ALU: add/sub with flags, logic ops, compares, shifts.
// Define ALU_PIPE_MUL_EN to add the iterative shift-add multiplier (opcode 1010, BUSY state).
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLTU = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t state, state_d, start_state;

  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;
  logic             accept;

  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    sum_w   = {1'b0, SrcA} + {1'b0, SrcB};
    // Bit WIDTH of the difference is a borrow, so Carry is its inverse.
    diff_w  = {1'b0, SrcA} - {1'b0, SrcB};
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        res_c   = sum_w[WIDTH-1:0];
        carry_c = sum_w[WIDTH];
        ovf_c   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum_w[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = diff_w[WIDTH-1:0];
        carry_c = ~diff_w[WIDTH];
        ovf_c   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff_w[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND:  res_c = SrcA & SrcB;
      OP_OR:   res_c = SrcA | SrcB;
      OP_XOR:  res_c = SrcA ^ SrcB;
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLL:  res_c = SrcA << shamt;
      OP_SRL:  res_c = SrcA >> shamt;
      OP_SRA:  res_c = $signed(SrcA) >>> shamt;
      default: res_c = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   count;
  logic             mul_last;
  logic             is_mul;

  assign is_mul      = (ALUControl == OP_MUL);
  assign acc_next    = acc + (mplier[0] ? mcand : '0);
  assign mul_last    = (count == SHW'(WIDTH - 1));
  assign start_state = is_mul ? BUSY : DONE;
`else
  assign start_state = DONE;
`endif

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = start_state;
      end
`ifdef ALU_PIPE_MUL_EN
      BUSY: begin
        if (mul_last) state_d = DONE;
      end
`endif
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? start_state : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
`endif
    end else begin
      state <= state_d;
`ifdef ALU_PIPE_MUL_EN
      if (accept && is_mul) begin
        mcand  <= SrcA;
        mplier <= SrcB;
        acc    <= '0;
        count  <= '0;
      end else if (accept) begin
        result_q <= res_c;
        carry_q  <= carry_c;
        ovf_q    <= ovf_c;
      end else if (state == BUSY) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (mul_last) begin
          result_q <= acc_next;
          carry_q  <= 1'b0;
          ovf_q    <= 1'b0;
        end
      end
`else
      if (accept) begin
        result_q <= res_c;
        carry_q  <= carry_c;
        ovf_q    <= ovf_c;
      end
`endif
    end
  end

  assign out_valid = (state == DONE);
  assign ALUResult = result_q;
  assign Zero      = (result_q == '0);
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32) against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 32;

`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic [3:0]    ALUControl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ALUResult;
  logic          Zero;
  logic          Carry;
  logic          Overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUControl(ALUControl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .Carry     (Carry),
    .Overflow  (Overflow)
  );

  // Returns {result, zero, carry, overflow} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c;
    logic         v;
    longint       ur;
    longint       sr;
    longint       p;
    longint       sa;
    int           amt;
    logic [63:0]  prod;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    amt = int'(b[4:0]);
    p   = longint'(1) << amt;
    sa  = longint'($signed(a));
    case (op)
      4'd0: begin
        ur = longint'(a) + longint'(b);
        r  = ur[W-1:0];
        c  = (ur >= 64'sd4294967296);
        sr = sa + longint'($signed(b));
        v  = (sr != longint'($signed(r)));
      end
      4'd1: begin
        ur = longint'(a) - longint'(b);
        r  = ur[W-1:0];
        c  = (a >= b);
        sr = sa - longint'($signed(b));
        v  = (sr != longint'($signed(r)));
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (a < b) ? 32'd1 : 32'd0;
      4'd6: r = (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd7: begin
        ur = longint'(a) * p;
        r  = ur[W-1:0];
      end
      4'd8: begin
        ur = longint'(a) / p;
        r  = ur[W-1:0];
      end
      4'd9: begin
        sr = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        r  = sr[W-1:0];
      end
      4'd10: begin
        prod = {32'd0, a} * {32'd0, b};
        r    = MUL_EN ? prod[W-1:0] : '0;
      end
      default: r = '0;
    endcase
    return {r, (r == '0), c, v};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present an op with out_ready high, wait (bounded) for in_ready, then let it be accepted.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n          = 0;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_in_ready: got %b, required 1 within 100 cycles", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    SrcA      = '0;
    SrcB      = '0;
    ALUControl = 4'd0;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    n_cmp++; if (ALUResult !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h, required 00000000", ALUResult); end
    n_cmp++; if (Zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b, required 1", Zero); end
    n_cmp++; if (Carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b, required 0", Carry); end
    n_cmp++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", Overflow); end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [3:0]   ops  [6] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd9, 4'd7};
    logic [W-1:0] as   [6] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd1};
    logic [W-1:0] bs   [6] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h24, 32'd31};
    logic [W+2:0] exps [6] = '{{32'h80000000, 3'b001}, {32'h00000000, 3'b110},
                               {32'h00000000, 3'b100}, {32'h00000001, 3'b000},
                               {32'hF8000000, 3'b000}, {32'h80000000, 3'b000}};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: out_valid %b, required 1 one cycle after accept", i, out_valid);
      end
      n_cmp++;
      if ({ALUResult, Zero, Carry, Overflow} !== exps[i]) begin
        n_fail++;
        $display("FAIL directed_op%0d[%0d]: got %h z%b c%b v%b, required %h z%b c%b v%b", ops[i], i,
                 ALUResult, Zero, Carry, Overflow, exps[i][W+2:3], exps[i][2], exps[i][1], exps[i][0]);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] edges [5] = '{32'd0, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+2:0] exp;
    int           cyc;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      exp = model(op, a, b);
      issue(op, a, b);
      if (MUL_EN && op == 4'd10) wait_valid(cyc);
      n_cmp++;
      if (out_valid !== 1'b1 ||
          {ALUResult, Zero, Carry, Overflow} !== exp) begin
        n_fail++;
        $display("FAIL random_op%0d a=%h b=%h: got v%b %h z%b c%b o%b, required v1 %h z%b c%b o%b", op, a, b,
                 out_valid, ALUResult, Zero, Carry, Overflow, exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]   ops [3] = '{4'd0, 4'd4, 4'd2};
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic [W+2:0] m;
    for (int i = 0; i < 3; i++) begin
      a          = $urandom;
      b          = $urandom;
      m          = model(ops[i], a, b);
      exp_r      = m[W+2:3];
      ALUControl = ops[i];
      SrcA       = a;
      SrcB       = b;
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || ALUResult !== exp_r) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got v%b %h, required v1 %h", i, out_valid, ALUResult, exp_r);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || ALUResult !== exp_r || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v%b %h rdy%b, required v1 %h rdy0", i, out_valid, ALUResult, in_ready, exp_r);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain: got v%b rdy%b, required v0 rdy1", out_valid, in_ready);
    end
  endtask

  task automatic test_mul;
    int           cnt;
    bit           busy_ready;
    int           exp_cnt;
    logic [W-1:0] exp_r;
    exp_cnt    = MUL_EN ? 33 : 1;
    exp_r      = MUL_EN ? 32'h0005000F : 32'd0;
    busy_ready = 1'b0;
    ALUControl = 4'd10;
    SrcA       = 32'h00010003;
    SrcB       = 32'h00000005;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    tick();
    // Junk request held during BUSY must be ignored.
    SrcA       = $urandom;
    SrcB       = $urandom;
    ALUControl = 4'd0;
    cnt        = 1;
    while (!out_valid && cnt < 100) begin
      if (in_ready) busy_ready = 1'b1;
      tick();
      cnt++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cnt != exp_cnt) begin
      n_fail++;
      $display("FAIL mul_latency: out_valid after %0d cycles, required %0d", cnt, exp_cnt);
    end
    n_cmp++;
    if (busy_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_busy_in_ready: in_ready seen %b while busy, required 0", busy_ready);
    end
    n_cmp++;
    if (ALUResult !== exp_r || Zero !== (exp_r == '0) || Carry !== 1'b0 || Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_result: got %h z%b c%b o%b, required %h z%b c0 o0", ALUResult, Zero, Carry, Overflow,
               exp_r, (exp_r == '0));
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || ALUResult !== exp_r) begin
      n_fail++;
      $display("FAIL mul_hold: got v%b %h, required v1 %h", out_valid, ALUResult, exp_r);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_busy;
    bit seen;
    ALUControl = 4'd10;
    SrcA       = 32'h12345678;
    SrcB       = 32'h9ABCDEF1;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_abort: got v%b rdy%b %h z%b, required v0 rdy1 00000000 z1", out_valid, in_ready,
               ALUResult, Zero);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: out_valid seen %b after abort, required 0", seen);
    end
    issue(4'd0, 32'd2, 32'd3);
    n_cmp++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd5) begin
      n_fail++;
      $display("FAIL post_reset_add: got v%b %h, required v1 00000005", out_valid, ALUResult);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mul();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the datapath's combinational ALU. Registers its result behind a valid/ready interface, adds shifts, signed/unsigned compare, carry/overflow flags and an optional iterative multiplier. Sits between operand fetch and writeback in multicycle/pipelined cores. Operand capture and result hold follow a three-state FSM.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits (≥ 8, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept an operation this cycle
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B
- ALUControl  input  4  operation code
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- ALUResult  output  WIDTH  registered result
- Zero  output  1  ALUResult == 0
- Carry  output  1  carry-out (ADD) / no-borrow (SUB); 0 otherwise
- Overflow  output  1  signed overflow (ADD/SUB); 0 otherwise

## Operation
- Opcodes: 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 SLTU (unsigned A<B → 1, legacy SLT semantics); 0110 SLT (signed); 0111 SLL; 1000 SRL; 1001 SRA; 1010 MUL (low WIDTH bits of A*B); 1011–1111 → result 0.
- Shifts use SrcB[SHW-1:0] only; upper bits ignored.
- ADD/SUB computed at WIDTH+1 bits; Carry = bit WIDTH (SUB: 1 when A ≥ B unsigned). Overflow = operand signs equal (ADD) / differ (SUB) and result sign differs from A.
- Zero always derived from the registered ALUResult, all ops.
- FSM: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Handshake (in_valid) → non-MUL: compute, register result, go DONE; MUL: latch operands, clear accumulator, go BUSY.
  - BUSY: in_ready=0. Shift-add one multiplier bit per cycle; after WIDTH iterations register result, go DONE. in_valid ignored.
  - DONE: out_valid=1; outputs stable until out_ready. in_ready = out_ready. out_ready & in_valid → accept new op in same cycle (back-to-back); out_ready only → IDLE.
- Reset: state IDLE, out_valid=0, in_ready=1 after reset, ALUResult=0, Zero=1, Carry=0, Overflow=0. Reset during BUSY/DONE aborts; result discarded.

## Timing
- Non-MUL latency 1: accepted at edge N, out_valid high from cycle N+1.
- MUL latency WIDTH+1: accepted at edge N, BUSY N+1…N+WIDTH, out_valid from N+WIDTH+1.
- Throughput: one non-MUL op per cycle while out_ready held high.
- out_valid held with stable data under backpressure; no result dropped or duplicated.
- in_ready combinational from state and out_ready only (no path from in_valid).

## Configuration
- ALU_PIPE_MUL_EN defined: MUL opcode 1010 uses the iterative multiplier, BUSY state present.
- Not defined: no multiplier logic or BUSY state; 1010 treated as unsupported → result 0, Zero=1, latency 1.

## Test plan
- Reset → out_valid=0, in_ready=1, ALUResult=0, Zero=1, Carry=0, Overflow=0.
- WIDTH=32, ADD 0x7FFFFFFF+1 → 0x80000000, Overflow=1, Carry=0; SUB 5−5 → 0, Zero=1, Carry=1, one cycle later.
- SLTU 0xFFFFFFFF vs 1 → 0; SLT same operands → 1; SRA 0x80000000 by 0x24 (amount 4) → 0xF8000000; SLL 1 by 31 → 0x80000000.
- Back-to-back ADD, XOR, AND with out_ready=1 every cycle → three results on three consecutive cycles; then out_ready=0 for 3 cycles → result held, in_ready=0.
- With ALU_PIPE_MUL_EN: MUL 0x0001_0003 × 0x0000_0005 → 0x0005_000F, out_valid at cycle N+33, in_ready=0 while BUSY; without macro → 0, latency 1.
- Reset asserted mid-BUSY → next cycle IDLE, out_valid=0; subsequent ADD 2+3 → 5.
